uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_tx.sv | 177 +++++++++++++++++
 tb/tb_uart_tx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame constants and divisor helper.
// Written so the UART receiver can adopt the same package later.
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
    } uart_state_e;

    function automatic int calc_divisor(input int sysclk, input int baudrate);
        return sysclk / baudrate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period down-counter: reload starts a bit at DIVISOR-1, tick is high
// on the final clock of the bit (count at zero). Saturates at zero.
module uart_baud_gen #(
    parameter int DIVISOR = 10,
    parameter int CNT_W   = $clog2(DIVISOR)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             reload,
    output logic [CNT_W-1:0] count,
    output logic             tick
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (reload) begin
            count_reg <= CNT_W'(DIVISOR - 1);
        end else if (count_reg != '0) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign count = count_reg;
    assign tick  = (count_reg == '0);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register for gapless frames.
// Define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd).
module uart_tx
    import uart_pkg::*;
#(
    parameter int SYSCLK   = 100_000_000,
    parameter int BAUDRATE = 57600,
    parameter int DIVISOR  = calc_divisor(SYSCLK, BAUDRATE)
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    uart_state_e      state_reg, state_next;
    logic [7:0]       shift_reg, shift_next;
    logic [2:0]       idx_reg, idx_next;
    logic [7:0]       hold_reg, hold_next;
    logic             full_reg, full_next;
    logic             ready_reg, txd_reg, busy_reg, done_reg;
    logic             txd_next, done_next, reload, accept;
    logic [CNT_W-1:0] baud_count;
    logic             baud_tick;
`ifdef UART_TX_PARITY_EN
    logic             par_reg, par_next;
`endif

    uart_baud_gen #(
        .DIVISOR (DIVISOR),
        .CNT_W   (CNT_W)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .reload (reload),
        .count  (baud_count),
        .tick   (baud_tick)
    );

    // ready_reg mirrors "holding register empty", so an accept never
    // collides with the handoff that empties it.
    assign accept = tx_valid & ready_reg;

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        idx_next   = idx_reg;
        hold_next  = hold_reg;
        full_next  = full_reg;
        reload     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_next   = par_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (full_reg) begin
                    shift_next = hold_reg;
                    full_next  = 1'b0;
                    state_next = ST_START;
                    reload     = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_next   = (^hold_reg) ^ PARITY_ODD;
`endif
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    state_next = ST_DATA;
                    idx_next   = '0;
                    reload     = 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    shift_next = shift_reg >> 1;
                    reload     = 1'b1;
                    if (idx_reg == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) begin
                    state_next = ST_STOP;
                    reload     = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_tick) begin
                    if (full_reg) begin
                        shift_next = hold_reg;
                        full_next  = 1'b0;
                        state_next = ST_START;
                        reload     = 1'b1;
`ifdef UART_TX_PARITY_EN
                        par_next   = (^hold_reg) ^ PARITY_ODD;
`endif
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (accept) begin
            hold_next = tx_data;
            full_next = 1'b1;
        end

        case (state_next)
            ST_START: txd_next = 1'b0;
            ST_DATA:  txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_next = par_next;
`endif
            default:  txd_next = IDLE_LEVEL;
        endcase

        // Counter is 1 now, so it reads 0 (last stop clock) after this edge.
        done_next = (state_reg == ST_STOP) && (baud_count == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            idx_reg   <= '0;
            hold_reg  <= '0;
            full_reg  <= 1'b0;
            ready_reg <= 1'b0;
            txd_reg   <= IDLE_LEVEL;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            idx_reg   <= idx_next;
            hold_reg  <= hold_next;
            full_reg  <= full_next;
            ready_reg <= ~full_next;
            txd_reg   <= txd_next;
            busy_reg  <= (state_next != ST_IDLE);
            done_reg  <= done_next;
`ifdef UART_TX_PARITY_EN
            par_reg   <= par_next;
`endif
        end
    end

    assign tx_ready = ready_reg;
    assign txd      = txd_reg;
    assign tx_busy  = busy_reg;
    assign tx_done  = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIVISOR=10: framing, back-to-back handoff,
// mid-frame reset, handshake rules and a mid-bit sampling receiver.
module tb_uart_tx;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, txd, tx_busy, tx_done;

    int vectors = 0;
    int miscompares = 0;

    uart_tx #(
        .SYSCLK   (1_000_000),
        .BAUDRATE (100_000)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD (1'b0)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .txd      (txd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_ready);
        chk({tag, "_txd"},   {7'd0, txd},      8'd1);
        chk({tag, "_busy"},  {7'd0, tx_busy},  8'd0);
        chk({tag, "_done"},  {7'd0, tx_done},  8'd0);
        chk({tag, "_ready"}, {7'd0, tx_ready}, {7'd0, exp_ready});
    endtask

    // Called just after the accept (or handoff-preceding) edge; checks every
    // clock of the frame. With has_next, the next byte is offered and accepted
    // at the second clock so it queues behind this one.
    task automatic send_frame(input logic [7:0] b, input logic [7:0] nxt, input bit has_next);
        logic [7:0] rx;
        logic       exp_txd;
        int         bit_i;
        rx = 8'h00;
        if (has_next) begin
            tx_valid = 1'b1;
            tx_data  = nxt;
        end else begin
            tx_data  = ~b;
        end
        for (int k = 1; k <= FRAME; k++) begin
            step();
            if (has_next && k == 2) begin
                tx_valid = 1'b0;
                tx_data  = ~nxt;
            end
            bit_i = (k - 1) / DIV;
            if (bit_i == 0)                  exp_txd = 1'b0;
            else if (bit_i <= 8)             exp_txd = b[bit_i-1];
            else if (bit_i == NBITS - 1)     exp_txd = 1'b1;
            else                             exp_txd = ^b;
            if ((k - 1) % DIV == DIV / 2 && bit_i >= 1 && bit_i <= 8)
                rx[bit_i-1] = txd;
            chk("txd",   {7'd0, txd},      {7'd0, exp_txd});
            chk("busy",  {7'd0, tx_busy},  8'd1);
            chk("done",  {7'd0, tx_done},  {7'd0, (k == FRAME)});
            chk("ready", {7'd0, tx_ready}, {7'd0, !(has_next && k >= 2)});
        end
        chk("rx_byte", rx, b);
        $display("frame sent=%02h received=%02h queued_next=%0d", b, rx, has_next);
    endtask

    task automatic accept_byte(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        step();
        tx_valid = 1'b0;
        chk("ready_after_accept", {7'd0, tx_ready}, 8'd0);
    endtask

    initial begin
        // Reset state, with a byte offered during reset that must be ignored.
        tx_valid = 1'b1;
        tx_data  = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("reset", 1'b0);
        end
        tx_valid = 1'b0;
        rst = 1'b0;
        step();
        chk_idle("release", 1'b1);
        step();
        chk_idle("idle", 1'b1);

        // Single frame 0xA5.
        accept_byte(8'hA5);
        send_frame(8'hA5, 8'h00, 1'b0);
        step();
        chk_idle("after_a5", 1'b1);

        // Back-to-back 0x00 then 0xFF with no idle gap.
        accept_byte(8'h00);
        send_frame(8'h00, 8'hFF, 1'b1);
        send_frame(8'hFF, 8'h00, 1'b0);
        step();
        chk_idle("after_ff", 1'b1);

        // Mid-frame reset during data bit 3 with 0x11 buffered.
        accept_byte(8'h96);
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        step();
        step();
        tx_valid = 1'b0;
        chk("buffered_ready", {7'd0, tx_ready}, 8'd0);
        for (int k = 3; k <= 45; k++) step();
        chk("mid_bit3_txd", {7'd0, txd}, {7'd0, 1'b0});
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_idle("mid_reset", 1'b0);
        end
        tx_valid = 1'b0;
        rst = 1'b0;
        step();
        chk_idle("post_abort", 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("discarded_busy", {7'd0, tx_busy}, 8'd0);
            chk("discarded_done", {7'd0, tx_done}, 8'd0);
        end
        accept_byte(8'h3C);
        send_frame(8'h3C, 8'h00, 1'b0);
        step();
        chk_idle("after_3c", 1'b1);

        // Loopback-style burst, decoded by mid-bit sampling.
        accept_byte(8'h00);
        send_frame(8'h00, 8'h55, 1'b1);
        send_frame(8'h55, 8'hAA, 1'b1);
        send_frame(8'hAA, 8'hFF, 1'b1);
        send_frame(8'hFF, 8'h81, 1'b1);
        send_frame(8'h81, 8'h00, 1'b0);
        step();
        chk_idle("after_burst", 1'b1);

        // Three data ones: even parity bit is 1 when parity is enabled.
        accept_byte(8'h07);
        send_frame(8'h07, 8'h00, 1'b0);
        step();
        chk_idle("after_07", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
